regfile_wb_queue: RTL and testbench

Writer-side front end for the core's register file write port (w_addr_reg / w_data_reg / w_ctrl_reg).
- Buffers completed results {rd, data} from the execute/memory stages in a small FIFO.
- Drains one result per cycle into the register file.
- Reports which source registers still have writes in flight, and optionally forwards the youngest queued value, so decode can stall or bypass.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_wb_lookup.sv | 39 +++
 rtl/regfile_wb_queue.sv | 83 ++++++++
 tb/tb_regfile_wb_queue.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, write-back entry type and x0 constant for the register file write-back queue.
package regfile_pkg;
    localparam int REGISTER_COUNT = 32;
    localparam int DATA_LENGTH = 32;
    localparam int ADDR_W = $clog2(REGISTER_COUNT);
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
    typedef struct packed {
        logic [ADDR_W-1:0]      rd;
        logic [DATA_LENGTH-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_lookup.sv
// wb_lookup: busy/youngest-value search of queued write-backs for one source register.
// Youngest-value forwarding is built only when REGFILE_WB_FORWARD_EN is defined.
module wb_lookup
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW = $clog2(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0]  entries,
    input  logic [DEPTH-1:0]       valid,
    input  logic [PW-1:0]          tail,
    input  logic [ADDR_W-1:0]      rs_addr,
    output logic                   busy,
    output logic [DATA_LENGTH-1:0] fwd_data
);
    logic [DEPTH-1:0] hit;
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++)
            hit[i] = valid[i] && entries[i].rd == rs_addr && rs_addr != REG_ZERO;
    end
    assign busy = |hit;
`ifdef REGFILE_WB_FORWARD_EN
    logic [PW-1:0] idx;
    // Walk oldest to youngest so the entry nearest the tail wins.
    always_comb begin
        fwd_data = '0;
        idx = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = tail - PW'(i);
            if (hit[idx]) fwd_data = entries[idx].data;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{tail, entries};
    assign fwd_data = '0;
`endif
endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: FIFO of completed results draining one write per cycle into the register file.
// Define REGFILE_WB_FORWARD_EN to drive rsN_fwd_data with the youngest queued value.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_rd,
    input  logic [DATA_LENGTH-1:0]   in_data,
    input  logic                     wb_hold,
    output logic [ADDR_W-1:0]        w_addr_reg,
    output logic [DATA_LENGTH-1:0]   w_data_reg,
    output logic                     w_ctrl_reg,
    input  logic [ADDR_W-1:0]        rs1_addr,
    input  logic [ADDR_W-1:0]        rs2_addr,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [DATA_LENGTH-1:0]   rs1_fwd_data,
    output logic [DATA_LENGTH-1:0]   rs2_fwd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;
    logic [DEPTH-1:0]       valid_q, valid_d;
    wb_entry_t [DEPTH-1:0]  mem_q, mem_d;
    wb_entry_t              head_e;
    logic                   empty, push, pop;
    assign empty = count_q == '0;
    assign in_ready = count_q < CW'(DEPTH);
    // x0 results complete the handshake but are never stored.
    assign push = in_valid && in_ready && in_rd != REG_ZERO;
    assign w_ctrl_reg = !empty && !wb_hold && !rst;
    assign pop = w_ctrl_reg;
    assign head_e = empty ? '0 : mem_q[head_q];
    assign w_addr_reg = head_e.rd;
    assign w_data_reg = head_e.data;
    assign count = count_q;
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        valid_d = valid_q;
        mem_d = mem_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d = head_q + 1'b1;
        end
        if (push) begin
            mem_d[tail_q] = '{rd: in_rd, data: in_data};
            valid_d[tail_q] = 1'b1;
            tail_d = tail_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            valid_q <= '0;
            mem_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            mem_q <= mem_d;
        end
    end
    wb_lookup #(.DEPTH(DEPTH)) u_rs1 (
        .entries(mem_q), .valid(valid_q), .tail(tail_q), .rs_addr(rs1_addr),
        .busy(rs1_busy), .fwd_data(rs1_fwd_data)
    );
    wb_lookup #(.DEPTH(DEPTH)) u_rs2 (
        .entries(mem_q), .valid(valid_q), .tail(tail_q), .rs_addr(rs2_addr),
        .busy(rs2_busy), .fwd_data(rs2_fwd_data)
    );
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed scenarios with hand-computed expectations for regfile_wb_queue.
module tb_regfile_wb_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        wb_hold;
    logic [4:0]  w_addr_reg;
    logic [31:0] w_data_reg;
    logic        w_ctrl_reg;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic [31:0] rs1_fwd_data, rs2_fwd_data;
    logic [2:0]  count;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_wb_queue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .wb_hold(wb_hold),
        .w_addr_reg(w_addr_reg), .w_data_reg(w_data_reg), .w_ctrl_reg(w_ctrl_reg),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data), .count(count)
    );

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 1; in_rd = 5'd3; in_data = 32'h1234; wb_hold = 0;
        rs1_addr = 5'd3; rs2_addr = 5'd0;
        next_cycle();
        #1;
        tests++; if (w_ctrl_reg !== 1'b0) begin fails++; $display("FAIL reset_wctrl_during got=%b exp=0", w_ctrl_reg); end
        next_cycle();
        rst = 0; in_valid = 0;
        #1;
        tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got=%0d exp=0", count); end
        tests++; if (w_ctrl_reg !== 1'b0) begin fails++; $display("FAIL reset_wctrl got=%b exp=0", w_ctrl_reg); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests++; if ({rs1_busy, rs2_busy} !== 2'b00) begin fails++; $display("FAIL reset_busy got=%b exp=00", {rs1_busy, rs2_busy}); end
        tests++; if (w_addr_reg !== 5'd0 || w_data_reg !== 32'd0) begin fails++; $display("FAIL reset_wdata got=%0d/%h exp=0/0", w_addr_reg, w_data_reg); end
    endtask

    task automatic test_single_write();
        in_valid = 1; in_rd = 5'd5; in_data = 32'hDEADBEEF; rs1_addr = 5'd5;
        #1;
        tests++; if (rs1_busy !== 1'b0) begin fails++; $display("FAIL single_incoming_not_busy got=%b exp=0", rs1_busy); end
        next_cycle();
        in_valid = 0;
        #1;
        tests++; if (w_ctrl_reg !== 1'b1 || w_addr_reg !== 5'd5 || w_data_reg !== 32'hDEADBEEF) begin
            fails++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", w_ctrl_reg, w_addr_reg, w_data_reg); end
        tests++; if (rs1_busy !== 1'b1 || count !== 3'd1) begin fails++; $display("FAIL single_busy got=%b/%0d exp=1/1", rs1_busy, count); end
        next_cycle();
        #1;
        tests++; if (count !== 3'd0 || rs1_busy !== 1'b0 || w_ctrl_reg !== 1'b0) begin
            fails++; $display("FAIL single_after got=%0d/%b/%b exp=0/0/0", count, rs1_busy, w_ctrl_reg); end
    endtask

    task automatic test_full_hold();
        wb_hold = 1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1; in_rd = 5'(i); in_data = 32'h100 + i;
            next_cycle();
        end
        #1;
        tests++; if (count !== 3'd4 || in_ready !== 1'b0 || w_ctrl_reg !== 1'b0) begin
            fails++; $display("FAIL full_state got=%0d/%b/%b exp=4/0/0", count, in_ready, w_ctrl_reg); end
        in_rd = 5'd9; in_data = 32'h999;
        next_cycle();
        in_valid = 0; rs1_addr = 5'd3; rs2_addr = 5'd9;
        #1;
        tests++; if (count !== 3'd4 || rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
            fails++; $display("FAIL full_reject got=%0d/%b/%b exp=4/1/0", count, rs1_busy, rs2_busy); end
        wb_hold = 0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            tests++; if (w_ctrl_reg !== 1'b1 || w_addr_reg !== 5'(i) || w_data_reg !== 32'h100 + i) begin
                fails++; $display("FAIL drain_order%0d got=%b/%0d/%h exp=1/%0d/%h", i, w_ctrl_reg, w_addr_reg, w_data_reg, i, 32'h100 + i); end
            next_cycle();
        end
        #1;
        tests++; if (count !== 3'd0 || w_ctrl_reg !== 1'b0) begin fails++; $display("FAIL drain_empty got=%0d/%b exp=0/0", count, w_ctrl_reg); end
    endtask

    task automatic test_forward();
        logic [31:0] exp_fwd;
`ifdef REGFILE_WB_FORWARD_EN
        exp_fwd = 32'h22;
`else
        exp_fwd = 32'h0;
`endif
        wb_hold = 1; in_valid = 1; in_rd = 5'd7; in_data = 32'h11;
        next_cycle();
        in_data = 32'h22;
        next_cycle();
        in_valid = 0; rs1_addr = 5'd7; rs2_addr = 5'd8;
        #1;
        tests++; if (rs1_busy !== 1'b1 || rs1_fwd_data !== exp_fwd) begin
            fails++; $display("FAIL fwd_youngest got=%b/%h exp=1/%h", rs1_busy, rs1_fwd_data, exp_fwd); end
        tests++; if (rs2_busy !== 1'b0 || rs2_fwd_data !== 32'h0) begin
            fails++; $display("FAIL fwd_nomatch got=%b/%h exp=0/0", rs2_busy, rs2_fwd_data); end
        wb_hold = 0;
        #1;
        tests++; if (w_data_reg !== 32'h11 || w_ctrl_reg !== 1'b1) begin fails++; $display("FAIL fwd_drain1 got=%h/%b exp=11/1", w_data_reg, w_ctrl_reg); end
        next_cycle();
        #1;
        tests++; if (w_data_reg !== 32'h22 || rs1_busy !== 1'b1 || rs1_fwd_data !== exp_fwd) begin
            fails++; $display("FAIL fwd_drain2 got=%h/%b/%h exp=22/1/%h", w_data_reg, rs1_busy, rs1_fwd_data, exp_fwd); end
        next_cycle();
        #1;
        tests++; if (count !== 3'd0 || rs1_busy !== 1'b0 || rs1_fwd_data !== 32'h0) begin
            fails++; $display("FAIL fwd_after got=%0d/%b/%h exp=0/0/0", count, rs1_busy, rs1_fwd_data); end
    endtask

    task automatic test_x0_wrap();
        in_valid = 1; in_rd = 5'd0; in_data = 32'hBAD;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL x0_ready got=%b exp=1", in_ready); end
        next_cycle();
        in_valid = 0;
        #1;
        tests++; if (count !== 3'd0 || w_ctrl_reg !== 1'b0) begin fails++; $display("FAIL x0_dropped got=%0d/%b exp=0/0", count, w_ctrl_reg); end
        for (int i = 0; i <= 10; i++) begin
            in_valid = (i < 10); in_rd = 5'(i + 1); in_data = 32'hA0 + i;
            #1;
            if (i > 0) begin
                tests++; if (count !== 3'd1 || w_ctrl_reg !== 1'b1 || w_addr_reg !== 5'(i) || w_data_reg !== 32'hA0 + i - 1) begin
                    fails++; $display("FAIL stream%0d got=%0d/%b/%0d/%h exp=1/1/%0d/%h", i, count, w_ctrl_reg, w_addr_reg, w_data_reg, i, 32'hA0 + i - 1); end
            end
            next_cycle();
        end
        in_valid = 0;
        #1;
        tests++; if (count !== 3'd0 || w_ctrl_reg !== 1'b0) begin fails++; $display("FAIL stream_end got=%0d/%b exp=0/0", count, w_ctrl_reg); end
    endtask

    task automatic test_reset_mid();
        wb_hold = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_rd = 5'(11 + i); in_data = 32'hC0 + i;
            next_cycle();
        end
        in_valid = 0; rs1_addr = 5'd11; rs2_addr = 5'd13;
        #1;
        tests++; if (count !== 3'd3 || rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
            fails++; $display("FAIL mid_queued got=%0d/%b/%b exp=3/1/1", count, rs1_busy, rs2_busy); end
        wb_hold = 0; rst = 1;
        #1;
        tests++; if (w_ctrl_reg !== 1'b0) begin fails++; $display("FAIL mid_rst_wctrl got=%b exp=0", w_ctrl_reg); end
        next_cycle();
        rst = 0;
        #1;
        tests++; if (count !== 3'd0 || w_ctrl_reg !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            fails++; $display("FAIL mid_after got=%0d/%b/%b/%b exp=0/0/0/0", count, w_ctrl_reg, rs1_busy, rs2_busy); end
        next_cycle();
        #1;
        tests++; if (w_ctrl_reg !== 1'b0) begin fails++; $display("FAIL mid_quiet got=%b exp=0", w_ctrl_reg); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_write();
        test_full_hold();
        test_forward();
        test_x0_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
